div_seq: RTL

- Multi-cycle sequencer and iterative datapath for DIV/DIVU in the EX stage of the 5-stage MIPS pipeline.
- Accepts operands from EX and runs a 32-iteration restoring shift-subtract divide.
- Holds the pipeline via stallreq until the result is ready.
- Returns {remainder, quotient} for the HI/LO write path.

---
 rtl/div_seq_if.sv | 30 +++
 rtl/div_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/div_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq_if
//  Description : EX-stage <-> divider handshake bundle. master = EX stage,
//                slave = divider.
//  Revision    : 1.0  initial release
// ============================================================================
interface div_seq_if #(
    parameter int DATA_W = 32
);
    logic                  start;
    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
    logic                  annul;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;
    logic                  stallreq;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stallreq
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, stallreq
    );
endinterface
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Multi-cycle restoring shift-subtract divider for DIV/DIVU.
//                One quotient bit per cycle, signed fix-up on completion,
//                pipeline stall requested until the result is ready.
//  Revision    : 1.0  initial release
// ============================================================================
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  wire logic   clk,
    input  wire logic   rst,
    div_seq_if.slave    bus
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_DIVZERO = 2'd1;
    localparam logic [1:0] c_ON      = 2'd2;
    localparam logic [1:0] c_END     = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [1:0]          r_state_q,  w_state_d;
    logic [CNT_W-1:0]    r_cnt_q,    w_cnt_d;
    logic                r_signed_q, w_signed_d;
    logic                r_neg1_q,   w_neg1_d;
    logic                r_neg2_q,   w_neg2_d;
    logic [DATA_W-1:0]   r_dvd_q,    w_dvd_d;   // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]   r_dvs_q,    w_dvs_d;
    logic [DATA_W-1:0]   r_rem_q,    w_rem_d;
    logic [2*DATA_W-1:0] r_result_q, w_result_d;
    logic                r_ready_q,  w_ready_d;

    logic                w_in_neg1, w_in_neg2;
    logic [DATA_W-1:0]   w_abs1, w_abs2;
    logic [DATA_W:0]     w_trial, w_diff;
    logic                w_fits;
    logic [DATA_W-1:0]   w_rem_step, w_quo_step, w_rem_fix, w_quo_fix;

    // Operand conditioning and one restoring-division iteration.
    always_comb begin
        w_in_neg1  = bus.signed_div & bus.opdata1[DATA_W-1];
        w_in_neg2  = bus.signed_div & bus.opdata2[DATA_W-1];
        w_abs1     = w_in_neg1 ? -bus.opdata1 : bus.opdata1;
        w_abs2     = w_in_neg2 ? -bus.opdata2 : bus.opdata2;

        // Shift {rem, dvd} left by one and trial-subtract the divisor.
        w_trial    = {r_rem_q, r_dvd_q[DATA_W-1]};
        w_diff     = w_trial - {1'b0, r_dvs_q};
        w_fits     = ~w_diff[DATA_W];
        w_rem_step = w_fits ? w_diff[DATA_W-1:0] : w_trial[DATA_W-1:0];
        w_quo_step = {r_dvd_q[DATA_W-2:0], w_fits};

        // Truncating signed division: quotient negative when signs differ,
        // remainder follows the dividend's sign.
        w_quo_fix  = (r_signed_q & (r_neg1_q ^ r_neg2_q)) ? -w_quo_step : w_quo_step;
        w_rem_fix  = (r_signed_q & r_neg1_q) ? -w_rem_step : w_rem_step;
    end

    // Sequencer next-state; annul overrides every transition.
    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_signed_d = r_signed_q;
        w_neg1_d   = r_neg1_q;
        w_neg2_d   = r_neg2_q;
        w_dvd_d    = r_dvd_q;
        w_dvs_d    = r_dvs_q;
        w_rem_d    = r_rem_q;
        w_result_d = r_result_q;
        w_ready_d  = 1'b0;

        case (r_state_q)
            c_IDLE: begin
                w_result_d = '0;
                if (bus.start && !bus.annul) begin
                    if (bus.opdata2 == '0) begin
                        w_state_d = c_DIVZERO;
                    end else begin
                        w_state_d  = c_ON;
                        w_signed_d = bus.signed_div;
                        w_neg1_d   = w_in_neg1;
                        w_neg2_d   = w_in_neg2;
                        w_dvd_d    = w_abs1;
                        w_dvs_d    = w_abs2;
                        w_rem_d    = '0;
                        w_cnt_d    = '0;
                    end
                end
            end
            c_DIVZERO: begin
                w_state_d  = c_END;
                w_result_d = '0;
                w_ready_d  = 1'b1;
            end
            c_ON: begin
                w_dvd_d = w_quo_step;
                w_rem_d = w_rem_step;
                w_cnt_d = r_cnt_q + c_ONE;
                if (r_cnt_q == c_LAST) begin
                    w_state_d  = c_END;
                    w_result_d = {w_rem_fix, w_quo_fix};
                    w_ready_d  = 1'b1;
                end
            end
            c_END: begin
                w_state_d  = c_IDLE;
                w_result_d = '0;
            end
            default: begin
                w_state_d  = c_IDLE;
                w_result_d = '0;
            end
        endcase

        if (bus.annul) begin
            w_state_d  = c_IDLE;
            w_ready_d  = 1'b0;
            w_result_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_IDLE;
            r_cnt_q    <= '0;
            r_signed_q <= 1'b0;
            r_neg1_q   <= 1'b0;
            r_neg2_q   <= 1'b0;
            r_dvd_q    <= '0;
            r_dvs_q    <= '0;
            r_rem_q    <= '0;
            r_result_q <= '0;
            r_ready_q  <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_signed_q <= w_signed_d;
            r_neg1_q   <= w_neg1_d;
            r_neg2_q   <= w_neg2_d;
            r_dvd_q    <= w_dvd_d;
            r_dvs_q    <= w_dvs_d;
            r_rem_q    <= w_rem_d;
            r_result_q <= w_result_d;
            r_ready_q  <= w_ready_d;
        end
    end

    // Stall drops in the ready cycle so the pipeline advances with the result.
    always_comb begin
        bus.result   = r_result_q;
        bus.ready    = r_ready_q;
        bus.stallreq = bus.start & ~r_ready_q;
    end

endmodule
`default_nettype wire
